phase_gen: RTL and testbench
============================

# phase_gen

Frame sequencer that sits directly upstream of the nibble-capture stage. Accepts 4-bit words over a valid/ready handshake and presents each word on `a0`, held stable for one 8-phase frame. Drives the 3-bit phase count `clk_out` and `enable` for the whole frame, so downstream can sample at phases 4 and 6. Runs bursts of N frames, or free-runs until stopped.

## Interface
- `DATA_W`, 4, width of `in_data` / `a0`
- `PHASE_W`, 3, phase counter width; a frame is 2^PHASE_W phases
- `BURST_W`, 8, width of `burst_len`
- `clk`  in  1  sole clock, rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `start`  in  1  begin a burst; honoured only in IDLE
- `stop`  in  1  request end of burst; sticky until burst ends
- `burst_len`  in  BURST_W  frames per burst, sampled on accepted `start`; 0 = free-run
- `in_data`  in  DATA_W  word to present for the next frame
- `in_valid`  in  1  `in_data` valid
- `in_ready`  out  1  block accepts `in_data` this cycle
- `clk_out`  out  PHASE_W  current phase, 0..7
- `enable`  out  1  frame phases 1..7 are active
- `a0`  out  DATA_W  word held for the current frame
- `frame_strb`  out  1  one-cycle pulse on phase 7
- `busy`  out  1  state is not IDLE
- `done`  out  1  one-cycle pulse when a burst ends

## Operation
- States:
  - IDLE: waiting for `start`.
  - LOAD: phase 0, waiting for a word.
  - RUN: phases 1..7.
  - DONE: one cycle, then IDLE.
- IDLE: `start` goes to LOAD with `clk_out`=0. `busy`=1 from that cycle. `stop` in IDLE is ignored and does not latch.
- LOAD:
  - `in_ready`=1. On `in_valid && in_ready`: `a0` <= `in_data`, `clk_out` <= 1, go to RUN.
  - No valid: stall in LOAD, `clk_out` stays 0, `enable`=0.
  - A pending or arriving `stop` aborts to DONE with no handshake; `a0` keeps its old value.
- RUN:
  - `enable`=1, `clk_out` +1 per cycle, `in_ready`=0.
  - At `clk_out`==7: `frame_strb`=1 and the frame counter increments.
  - Go to DONE if the stop latch is set, or if `burst_len`≠0 and the counter equals `burst_len`. Otherwise wrap `clk_out` to 0 and go to LOAD.
- Stop rules: `stop` during RUN latches and always lets the current frame complete. The latch clears on entering DONE.
- DONE: `done`=1, `enable`=0, `clk_out`=0, then IDLE.
- Frame counter: BURST_W bits, cleared on accepted `start`. In free-run it wraps modulo 2^BURST_W with no effect on control.
- `a0` changes only on a LOAD handshake, so it is constant across phases 1..7.
- `start` outside IDLE is ignored.

## Timing
- Reset (async assert, sync release): state IDLE. All outputs 0: `clk_out`, `enable`, `a0`, `in_ready`, `frame_strb`, `busy`, `done`. Stop latch and frame counter are cleared.
- Reset asserted mid-frame returns immediately to these values. No `done` pulse is issued.
- `start`, then `clk_out`=0 / LOAD on the next cycle.
- Handshake cycle, then phase 1 on the next cycle.
- Minimum frame is 8 cycles (LOAD plus 7 RUN). Every stall cycle in LOAD adds one.
- Last phase 7 → `done` on the next cycle → IDLE on the following cycle.
- Back-to-back frames are gapless when `in_valid` is already high at LOAD.
- All outputs are registered.

## Configuration
- `PHASE_GEN_PAUSE_EN`
  - Defined: adds input `pause` (1 bit). While `pause`=1 in RUN, `clk_out` and the frame counter hold and `enable`=0. Resumes at the held phase. `pause` in other states has no effect. `stop` still latches during pause.
  - Undefined: no `pause` port, and RUN never stalls.

## Structure
- Package `phase_gen_pkg`:
  - state enum (IDLE, LOAD, RUN, DONE)
  - PHASE_W default
  - `PHASE_LAST`=7
  - downstream sample phase constants (4, 6)
- Sub-module `phase_ctr`: the wrapping PHASE_W counter with clear/advance/hold inputs and a last-phase flag. The FSM, handshake and `a0` register stay in the top.

## Test plan
- Reset mid-RUN at `clk_out`=5 → all outputs 0 the same cycle, IDLE after release.
- `burst_len`=2, `in_valid` held high, words 0x3 then 0xA → `a0`=3 for phases 1..7, then `a0`=A. 16 cycles of phases, `frame_strb` pulses twice, a single `done`, `busy` falls after.
- `in_valid` low for 3 cycles in LOAD → `clk_out` holds 0, `enable`=0, frame stretches to 11 cycles, no data loss.
- `burst_len`=0, `stop` pulsed at phase 3 of frame 5 → frame 5 completes through phase 7, then `done`. The frame counter reads 5.
- `stop` while stalled in LOAD → DONE next cycle, no handshake, `a0` unchanged. `start` during RUN → ignored.
- With `PHASE_GEN_PAUSE_EN` defined, `pause` for 4 cycles at phase 4 → `clk_out` holds at 4, `enable`=0, frame takes 12 cycles.

Source files
------------

// File: rtl/phase_gen_pkg.sv
// phase_gen_pkg -- shared types and constants for the phase_gen frame sequencer.
//   state_t          : sequencer states (IDLE, LOAD, RUN, DONE)
//   PHASE_W_DEFAULT  : default phase counter width (frame = 2**PHASE_W phases)
//   PHASE_LAST       : last phase of a default-width frame
//   SAMPLE_PHASE_*   : phases at which the downstream nibble-capture stage samples a0
package phase_gen_pkg;

   localparam int PHASE_W_DEFAULT = 3;
   localparam int PHASE_LAST      = 7;
   localparam int SAMPLE_PHASE_A  = 4;
   localparam int SAMPLE_PHASE_B  = 6;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

endpackage

// File: rtl/phase_gen_phase_ctr.sv
// phase_ctr -- wrapping PHASE_W-bit phase counter.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : force phase to 0 (wins over adv)
//   adv        : advance phase by one, wrapping from the last phase to 0
//   phase      : current phase (registered)
//   last       : phase is the last phase of the frame
module phase_ctr
   import phase_gen_pkg::*;
#(
   parameter int PHASE_W = PHASE_W_DEFAULT
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clr,
   input  logic               adv,
   output logic [PHASE_W-1:0] phase,
   output logic               last
);

   logic [PHASE_W-1:0] phase_q;
   logic [PHASE_W-1:0] phase_d;

   always_comb begin
      phase_d = phase_q;
      if (clr) begin
         phase_d = '0;
      end else if (adv) begin
         phase_d = phase_q + 1'b1;   // natural wrap gives the return to phase 0
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase_q <= '0;
      end else begin
         phase_q <= phase_d;
      end
   end

   assign phase = phase_q;
   assign last  = (phase_q == {PHASE_W{1'b1}});

endmodule

// File: rtl/phase_gen.sv
// phase_gen -- frame sequencer feeding the nibble-capture stage.
// Accepts one DATA_W word per frame over valid/ready, holds it on a0 for a
// whole 2**PHASE_W-phase frame and drives the phase count on clk_out.
// Runs bursts of burst_len frames, or free-runs (burst_len = 0) until stop.
//   start/stop      : begin a burst (IDLE only) / request end of burst
//   burst_len       : frames per burst, captured on an accepted start
//   in_data/in_valid/in_ready : word handshake, accepted only in LOAD
//   clk_out, enable : current phase, high during active phases 1..7
//   a0              : word held for the current frame
//   frame_strb      : one-cycle pulse on the last phase
//   busy, done      : not IDLE / one-cycle end-of-burst pulse
// Optional feature: define PHASE_GEN_PAUSE_EN to add a `pause` input that
// freezes the phase and frame counter (enable low) while in RUN.
// All outputs are registered.
module phase_gen
   import phase_gen_pkg::*;
#(
   parameter int DATA_W  = 4,
   parameter int PHASE_W = PHASE_W_DEFAULT,
   parameter int BURST_W = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               stop,
   input  logic [BURST_W-1:0] burst_len,
   input  logic [DATA_W-1:0]  in_data,
   input  logic               in_valid,
`ifdef PHASE_GEN_PAUSE_EN
   input  logic               pause,
`endif
   output logic               in_ready,
   output logic [PHASE_W-1:0] clk_out,
   output logic               enable,
   output logic [DATA_W-1:0]  a0,
   output logic               frame_strb,
   output logic               busy,
   output logic               done
);

   localparam logic [PHASE_W-1:0] PH_PRE  = {{(PHASE_W-1){1'b1}}, 1'b0};
   localparam logic [BURST_W-1:0] CNT_ONE = {{(BURST_W-1){1'b0}}, 1'b1};

   state_t state_q, state_d;

   logic               stop_q, stop_d;
   logic [BURST_W-1:0] frame_cnt_q, frame_cnt_d;
   logic [BURST_W-1:0] burst_len_q, burst_len_d;
   logic [DATA_W-1:0]  a0_q, a0_d;
   logic               in_ready_q, in_ready_d;
   logic               enable_q, enable_d;
   logic               frame_strb_q, frame_strb_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   logic pause_i;
   logic start_acc;
   logic stop_eff;
   logic handshake;
   logic run_adv;
   logic frame_end;
   logic burst_hit;
   logic phase_last;
   logic ctr_clr;
   logic ctr_adv;

`ifdef PHASE_GEN_PAUSE_EN
   assign pause_i = pause;
`else
   assign pause_i = 1'b0;
`endif

   assign start_acc = (state_q == ST_IDLE) && start;
   // A stop arriving this cycle counts the same as one already latched.
   assign stop_eff  = stop_q || stop;
   // in_ready_q is high exactly in LOAD; a concurrent stop wins over the word.
   assign handshake = (state_q == ST_LOAD) && in_ready_q && in_valid && !stop_eff;
   assign run_adv   = (state_q == ST_RUN) && !pause_i;
   assign frame_end = run_adv && phase_last;
   assign burst_hit = (burst_len_q != '0) && ((frame_cnt_q + CNT_ONE) == burst_len_q);

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (start) state_d = ST_LOAD;
         ST_LOAD: begin
            if (stop_eff)       state_d = ST_DONE;
            else if (handshake) state_d = ST_RUN;
         end
         ST_RUN: begin
            if (frame_end) state_d = (stop_eff || burst_hit) ? ST_DONE : ST_LOAD;
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // ---------------- FSM: outputs (registered from next state) ----------------
   always_comb begin
      in_ready_d   = (state_d == ST_LOAD);
      busy_d       = (state_d != ST_IDLE);
      done_d       = (state_d == ST_DONE);
      // Entering RUN from LOAD is never paused; only a RUN->RUN hold drops enable.
      enable_d     = (state_d == ST_RUN) && !((state_q == ST_RUN) && pause_i);
      frame_strb_d = run_adv && (clk_out == PH_PRE);
   end

   // ---------------- datapath: stop latch, frame counter, word ----------------
   always_comb begin
      stop_d      = stop_q;
      frame_cnt_d = frame_cnt_q;
      burst_len_d = burst_len_q;
      a0_d        = a0_q;

      if (state_q == ST_RUN && stop) stop_d = 1'b1;
      if (state_d == ST_DONE)        stop_d = 1'b0;

      if (start_acc) begin
         frame_cnt_d = '0;
         burst_len_d = burst_len;
      end else if (frame_end) begin
         frame_cnt_d = frame_cnt_q + CNT_ONE;
      end

      if (handshake) a0_d = in_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stop_q       <= 1'b0;
         frame_cnt_q  <= '0;
         burst_len_q  <= '0;
         a0_q         <= '0;
         in_ready_q   <= 1'b0;
         enable_q     <= 1'b0;
         frame_strb_q <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         stop_q       <= stop_d;
         frame_cnt_q  <= frame_cnt_d;
         burst_len_q  <= burst_len_d;
         a0_q         <= a0_d;
         in_ready_q   <= in_ready_d;
         enable_q     <= enable_d;
         frame_strb_q <= frame_strb_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

   // Phase wraps to 0 on the last RUN phase; IDLE/DONE hold it at 0.
   assign ctr_clr = (state_d == ST_IDLE) || (state_d == ST_DONE);
   assign ctr_adv = handshake || run_adv;

   phase_ctr #(
      .PHASE_W (PHASE_W)
   ) u_phase_ctr (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (ctr_clr),
      .adv   (ctr_adv),
      .phase (clk_out),
      .last  (phase_last)
   );

   assign in_ready   = in_ready_q;
   assign enable     = enable_q;
   assign a0         = a0_q;
   assign frame_strb = frame_strb_q;
   assign busy       = busy_q;
   assign done       = done_q;

endmodule

// File: tb/tb_phase_gen.sv
// tb_phase_gen -- self-checking bench for phase_gen.
// Words offered to the DUT are pushed to a scoreboard when accepted and
// popped when the frame they belong to starts (phase 1); a0 is compared on
// every enabled phase. Directed sequences cover reset, bursts, LOAD stalls,
// stop handling, ignored start and (with PHASE_GEN_PAUSE_EN) pause.
module tb_phase_gen;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       stop = 1'b0;
   logic [7:0] burst_len = 8'd0;
   logic [3:0] in_data = 4'h0;
   logic       in_valid = 1'b0;
   logic       pause = 1'b0;
   logic       in_ready;
   logic [2:0] clk_out;
   logic       enable;
   logic [3:0] a0;
   logic       frame_strb;
   logic       busy;
   logic       done;

   phase_gen dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .stop       (stop),
      .burst_len  (burst_len),
      .in_data    (in_data),
      .in_valid   (in_valid),
`ifdef PHASE_GEN_PAUSE_EN
      .pause      (pause),
`endif
      .in_ready   (in_ready),
      .clk_out    (clk_out),
      .enable     (enable),
      .a0         (a0),
      .frame_strb (frame_strb),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int strb_cnt = 0;
   int done_cnt = 0;
   logic [3:0] feed_q[$];
   logic [3:0] exp_q[$];
   logic [3:0] cur_exp = 4'h0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // Driver for in_data: presents the head of feed_q; accepted words go to the scoreboard.
   always @(posedge clk) begin
      if (rst_n && in_valid && in_ready && !stop) begin
         exp_q.push_back(in_data);
         if (feed_q.size() > 0) void'(feed_q.pop_front());
      end
      #1;
      in_data = (feed_q.size() > 0) ? feed_q[0] : 4'h0;
   end

   // Monitor: one scoreboard pop per frame, a0 checked on every active phase.
   always @(negedge clk) begin
      if (rst_n) begin
         if (enable && clk_out == 3'd1) begin
            if (exp_q.size() == 0) check("sb_empty", 1, 0);
            else cur_exp = exp_q.pop_front();
         end
         if (enable) check("a0", a0, cur_exp);
         if (frame_strb) strb_cnt++;
         if (done) done_cnt++;
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_done(input int limit, output int cyc);
      cyc = 0;
      while (done !== 1'b1 && cyc < limit) begin
         if (busy) cyc++;
         step();
      end
      check("done_seen", done, 1);
   endtask

   task automatic wait_phase(input logic [2:0] ph, input int limit);
      int k = 0;
      while (!(clk_out == ph && enable) && k < limit) begin
         step();
         k++;
      end
      check("phase_reached", clk_out, ph);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_clk_out"}, clk_out, 0);
      check({tag, "_enable"}, enable, 0);
      check({tag, "_a0"}, a0, 0);
      check({tag, "_in_ready"}, in_ready, 0);
      check({tag, "_frame_strb"}, frame_strb, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int cyc;
      int total;
      int base;
      int d0;
      int k;

      // ---- reset ----
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset");
      step();
      rst_n = 1'b1;
      step();
      check("idle_busy", busy, 0);

      // ---- burst of 2, in_valid held high, words 3 then A ----
      base = strb_cnt; d0 = done_cnt;
      burst_len = 8'd2; start = 1'b1; in_valid = 1'b1;
      feed_q.push_back(4'h3); feed_q.push_back(4'hA);
      step();
      start = 1'b0;
      check("b2_load_ready", in_ready, 1);
      check("b2_load_phase", clk_out, 0);
      check("b2_load_busy", busy, 1);
      check("b2_load_enable", enable, 0);
      wait_done(100, cyc);
      in_valid = 1'b0;
      check("b2_cycles", cyc, 16);
      check("b2_strobes", strb_cnt - base, 2);
      check("b2_done_enable", enable, 0);
      check("b2_done_phase", clk_out, 0);
      check("b2_done_busy", busy, 1);
      check("b2_final_a0", a0, 4'hA);
      step();
      check("b2_idle_busy", busy, 0);
      check("b2_idle_done", done, 0);
      check("b2_done_count", done_cnt - d0, 1);

      // ---- LOAD stall of 3 cycles, burst of 1 ----
      step();
      burst_len = 8'd1; start = 1'b1; in_valid = 1'b0;
      feed_q.push_back(4'h5);
      step();
      start = 1'b0;
      total = 0;
      repeat (3) begin
         check("stall_phase", clk_out, 0);
         check("stall_enable", enable, 0);
         check("stall_ready", in_ready, 1);
         total++;
         step();
      end
      in_valid = 1'b1;
      wait_done(100, cyc);
      in_valid = 1'b0;
      check("stall_frame_len", total + cyc, 11);
      check("stall_a0", a0, 4'h5);
      step();
      check("stall_idle_busy", busy, 0);

      // ---- free-run, stop at phase 3 of frame 5 ----
      step();
      base = strb_cnt;
      burst_len = 8'd0; start = 1'b1; in_valid = 1'b1;
      for (int i = 1; i <= 6; i++) feed_q.push_back(4'(i));
      step();
      start = 1'b0;
      k = 0;
      while (!(strb_cnt - base == 4 && clk_out == 3'd3 && enable) && k < 200) begin
         step();
         k++;
      end
      check("fr_stop_point", clk_out, 3);
      stop = 1'b1;
      step();
      stop = 1'b0;
      check("fr_continue_phase", clk_out, 4);
      check("fr_continue_enable", enable, 1);
      wait_done(100, cyc);
      in_valid = 1'b0;
      check("fr_strobes", strb_cnt - base, 5);
      check("fr_frame_cnt", dut.frame_cnt_q, 5);
      check("fr_done_ready", in_ready, 0);
      step();
      check("fr_idle_busy", busy, 0);
      check("fr_unused_words", feed_q.size(), 1);
      feed_q.delete();

      // ---- start during RUN ignored, stop while stalled in LOAD ----
      step();
      base = strb_cnt;
      burst_len = 8'd3; start = 1'b1; in_valid = 1'b1;
      feed_q.push_back(4'h7); feed_q.push_back(4'h9);
      step();
      start = 1'b0;
      wait_phase(3'd3, 50);
      start = 1'b1;
      step();
      start = 1'b0;
      check("ign_start_phase", clk_out, 4);
      check("ign_start_busy", busy, 1);
      wait_phase(3'd7, 50);
      in_valid = 1'b0;
      step();
      check("ls_load_phase", clk_out, 0);
      check("ls_load_ready", in_ready, 1);
      stop = 1'b1;
      step();
      stop = 1'b0;
      check("ls_done", done, 1);
      check("ls_done_ready", in_ready, 0);
      check("ls_a0_kept", a0, 4'h7);
      check("ls_strobes", strb_cnt - base, 1);
      step();
      check("ls_idle_busy", busy, 0);
      check("ls_unused_words", feed_q.size(), 1);
      feed_q.delete();

      // ---- reset asserted mid-RUN at phase 5 ----
      step();
      d0 = done_cnt;
      burst_len = 8'd0; start = 1'b1; in_valid = 1'b1;
      feed_q.push_back(4'hC);
      step();
      start = 1'b0;
      wait_phase(3'd5, 50);
      in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check_all_zero("midrst");
      step();
      step();
      rst_n = 1'b1;
      step();
      check("midrst_busy", busy, 0);
      check("midrst_ready", in_ready, 0);
      check("midrst_phase", clk_out, 0);
      check("midrst_no_done", done_cnt - d0, 0);

`ifdef PHASE_GEN_PAUSE_EN
      // ---- pause for 4 cycles at phase 4 ----
      begin
         int pc;
         bit pdone;
         step();
         burst_len = 8'd1; start = 1'b1; in_valid = 1'b1;
         feed_q.push_back(4'hE);
         step();
         start = 1'b0;
         cyc = 0; pc = 0; pdone = 1'b0;
         while (done !== 1'b1 && cyc < 100) begin
            if (busy) cyc++;
            if (pc > 0) begin
               check("pause_hold", clk_out, 4);
               check("pause_enable", enable, 0);
               pc--;
               if (pc == 0) pause = 1'b0;
            end else if (!pdone && clk_out == 3'd4 && enable) begin
               pause = 1'b1;
               pc = 4;
               pdone = 1'b1;
            end
            step();
         end
         in_valid = 1'b0;
         check("pause_done", done, 1);
         check("pause_frame_len", cyc, 12);
         step();
      end
`endif

      check("sb_drained", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
